fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the mini-rv 5-stage pipeline; sits directly upstream of decode and drives the IF/ID register (if_id_instr_data, if_id_pc).
Owns the PC and issues requests to instruction memory over a single-outstanding req/ack handshake.
Handles pipeline stall, branch/jump redirect from execute, and memory wait states, inserting NOP bubbles where no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding driven into IF/ID for bubbles (addi x0,x0,0)

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold IF/ID and PC
redirect  input  1  execute stage: taken branch/jump, flush fetch
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0)
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  word-aligned request address; stable while imem_req=1 and no ack
imem_ack  input  1  response valid this cycle; completes the outstanding request
imem_rdata  input  32  instruction word, valid when imem_ack=1
if_id_instr_data  output  32  IF/ID instruction register
if_id_pc  output  32  IF/ID PC register

Behaviour:
- Registers: pc (next address to deliver), req_addr (address of outstanding request), pend_pc (pending redirect target), buf (held instruction), state ∈ {REQ, HOLD, KILL}.
- Reset (rst=1 at posedge, overrides everything): state=REQ, pc=req_addr=RESET_PC, if_id_instr_data=NOP_INSTR, if_id_pc=RESET_PC, buf=0, pend_pc=0. imem_req=1 with imem_addr=RESET_PC in the first cycle after reset.
- imem_addr=req_addr at all times. imem_req=1 in REQ and KILL, 0 in HOLD.
- One request outstanding at most. A request completes in the same cycle imem_ack=1; zero-wait memory gives 1 instruction/cycle. The next request's req_addr updates at the ack edge.
- Priority within every state: rst > redirect > stall > normal.
- REQ:
  - ack & redirect: discard rdata. IF/ID <= {NOP_INSTR, redirect_pc}. pc=req_addr=redirect_pc. Stay in REQ.
  - ack & !redirect & !stall: IF/ID <= {imem_rdata, req_addr}. pc=req_addr=req_addr+4. Stay in REQ.
  - ack & !redirect & stall: buf<=imem_rdata. IF/ID holds. pc unchanged. Go to HOLD.
  - !ack & redirect: pend_pc<=redirect_pc. IF/ID <= NOP bubble. req_addr holds, because the address must stay stable. Go to KILL.
  - !ack & !redirect & !stall: IF/ID <= {NOP_INSTR, pc}, a wait-state bubble.
  - !ack & stall: IF/ID holds.
- HOLD (no request issued):
  - redirect: drop buf. IF/ID <= NOP. pc=req_addr=redirect_pc. Go to REQ.
  - !stall: IF/ID <= {buf, pc}. pc=req_addr=pc+4. Go to REQ.
  - stall: remain in HOLD.
- KILL (waiting to drain a stale request):
  - IF/ID <= NOP every cycle, regardless of stall.
  - A further redirect overwrites pend_pc.
  - On ack: discard rdata. pc=req_addr = (redirect ? redirect_pc : pend_pc). Go to REQ.
- Redirect always flushes IF/ID to NOP_INSTR, even with stall=1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
- No instruction is ever delivered twice or skipped absent a redirect.

Test Plan:
- Reset, zero-wait memory (ack every cycle, rdata=addr^32'hA5A5_0000) -> imem_addr sequence 0,4,8,C; IF/ID pc 0,4,8 in successive cycles with matching data.
- Memory with 2-cycle wait (ack on every 3rd cycle) -> two NOP bubbles between delivered instructions; imem_addr stable during wait.
- stall=1 asserted in the cycle ack for addr 8 arrives, held 3 cycles -> IF/ID keeps addr 4 instr; imem_req=0 in HOLD; after release IF/ID={instr@8, 8}, next req addr C.
- redirect to 32'h100 while request for 0x10 is outstanding with no ack -> KILL; response for 0x10 discarded; next req addr 0x100; IF/ID NOP until instr@0x100 delivered.
- redirect to 32'h203 with stall=1 and ack simultaneous -> IF/ID=NOP, next imem_addr 0x200.
- Reset asserted mid-KILL, and RESET_PC=32'hFFFF_FFFC wrap -> state REQ, imem_addr=RESET_PC; after one ack next imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight, and
// fills IF/ID with fetched words or NOP bubbles around stalls, redirects and wait states.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr_data,
  output logic [31:0] if_id_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_pend_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_imem_req;

  logic [31:0] w_redir_pc;
  logic        w_unused_lsbs;

  // Targets are word aligned; the low two bits of redirect_pc carry no information.
  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc[1:0];

  assign imem_req         = r_imem_req;
  assign imem_addr        = r_req_addr;
  assign if_id_instr_data = r_if_instr;
  assign if_id_pc         = r_if_pc;

  // Fetch FSM: PC, request address, held instruction and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_pend_pc   <= 32'h0000_0000;
      r_buf_instr <= 32'h0000_0000;
      r_if_instr  <= NOP_INSTR;
      r_if_pc     <= RESET_PC;
      r_imem_req  <= 1'b1;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              r_if_instr <= NOP_INSTR;
              r_if_pc    <= w_redir_pc;
              r_pc       <= w_redir_pc;
              r_req_addr <= w_redir_pc;
            end else if (!stall) begin
              r_if_instr <= imem_rdata;
              r_if_pc    <= r_req_addr;
              r_pc       <= r_req_addr + 32'd4;
              r_req_addr <= r_req_addr + 32'd4;
            end else begin
              // Decode is stalled: park the word and stop requesting until it is consumed.
              r_buf_instr <= imem_rdata;
              r_state     <= S_HOLD;
              r_imem_req  <= 1'b0;
            end
          end else begin
            if (redirect) begin
              // The in-flight address must stay stable, so drain it before retargeting.
              r_pend_pc  <= w_redir_pc;
              r_if_instr <= NOP_INSTR;
              r_if_pc    <= w_redir_pc;
              r_state    <= S_KILL;
            end else if (!stall) begin
              r_if_instr <= NOP_INSTR;
              r_if_pc    <= r_pc;
            end else begin
              r_if_instr <= r_if_instr;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= w_redir_pc;
            r_pc       <= w_redir_pc;
            r_req_addr <= w_redir_pc;
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end else if (!stall) begin
            r_if_instr <= r_buf_instr;
            r_if_pc    <= r_pc;
            r_pc       <= r_pc + 32'd4;
            r_req_addr <= r_pc + 32'd4;
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_KILL: begin
          r_if_instr <= NOP_INSTR;
          r_if_pc    <= redirect ? w_redir_pc : r_pend_pc;
          if (redirect) begin
            r_pend_pc <= w_redir_pc;
          end else begin
            r_pend_pc <= r_pend_pc;
          end
          if (imem_ack) begin
            r_pc       <= redirect ? w_redir_pc : r_pend_pc;
            r_req_addr <= redirect ? w_redir_pc : r_pend_pc;
            r_state    <= S_REQ;
          end else begin
            r_state <= S_KILL;
          end
        end
        default: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (default and wrapping RESET_PC) share
// stimulus; a spec-level model is compared every cycle, plus hand-computed literal pins.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ack;
  logic [31:0] redirect_pc;
  logic        req0, req1;
  logic [31:0] addr0, addr1, rdata0, rdata1, ins0, ins1, pc0, pc1;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Memory model: the word at an address is the address xor a fixed mask.
  assign rdata0 = addr0 ^ XMASK;
  assign rdata1 = addr1 ^ XMASK;

  fetch_stage u_dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack), .imem_rdata(rdata0),
    .if_id_instr_data(ins0), .if_id_pc(pc0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(rdata1),
    .if_id_instr_data(ins1), .if_id_pc(pc1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inflight;
    logic [31:0] target;
    logic [31:0] parked;
    logic [31:0] instr;
    logic [31:0] ifpc;
    bit          pc_known;
    bit          parked_valid;
    bit          draining;
  } mdl_t;

  mdl_t m [2];
  logic [31:0] boot_pc [2];

  function automatic mdl_t advance(mdl_t s, logic [31:0] bpc, bit r, bit st, bit rd,
                                   logic [31:0] rp, bit ak);
    mdl_t n = s;
    logic [31:0] tgt = rp & 32'hFFFF_FFFC;
    if (r) begin
      n.pc = bpc; n.inflight = bpc; n.instr = NOP; n.ifpc = bpc; n.pc_known = 1'b1;
      n.parked_valid = 1'b0; n.draining = 1'b0;
    end else if (s.draining) begin
      n.instr = NOP; n.pc_known = 1'b0;
      if (rd) n.target = tgt;
      if (ak) begin
        n.pc = n.target; n.inflight = n.target; n.draining = 1'b0;
      end
    end else if (s.parked_valid) begin
      if (rd) begin
        n.instr = NOP; n.pc_known = 1'b0; n.pc = tgt; n.inflight = tgt; n.parked_valid = 1'b0;
      end else if (!st) begin
        n.instr = s.parked; n.ifpc = s.pc; n.pc_known = 1'b1;
        n.pc = s.pc + 32'd4; n.inflight = n.pc; n.parked_valid = 1'b0;
      end
    end else if (ak) begin
      if (rd) begin
        n.instr = NOP; n.ifpc = tgt; n.pc_known = 1'b1; n.pc = tgt; n.inflight = tgt;
      end else if (!st) begin
        n.instr = s.inflight ^ XMASK; n.ifpc = s.inflight; n.pc_known = 1'b1;
        n.pc = s.inflight + 32'd4; n.inflight = n.pc;
      end else begin
        n.parked = s.inflight ^ XMASK; n.parked_valid = 1'b1;
      end
    end else if (rd) begin
      n.target = tgt; n.instr = NOP; n.pc_known = 1'b0; n.draining = 1'b1;
    end else if (!st) begin
      n.instr = NOP; n.ifpc = s.pc; n.pc_known = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("d0.req",   {31'd0, req0}, {31'd0, !m[0].parked_valid});
    chk("d0.addr",  addr0, m[0].inflight);
    chk("d0.instr", ins0,  m[0].instr);
    if (m[0].pc_known) chk("d0.pc", pc0, m[0].ifpc);
    chk("d1.req",   {31'd0, req1}, {31'd0, !m[1].parked_valid});
    chk("d1.addr",  addr1, m[1].inflight);
    chk("d1.instr", ins1,  m[1].instr);
    if (m[1].pc_known) chk("d1.pc", pc1, m[1].ifpc);
  endtask

  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rp,
                      input bit ak);
    rst = r; stall = st; redirect = rd; redirect_pc = rp; imem_ack = ak;
    @(posedge clk);
    for (int k = 0; k < 2; k++) m[k] = advance(m[k], boot_pc[k], r, st, rd, rp, ak);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    boot_pc[0] = 32'h0000_0000;
    boot_pc[1] = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      m[k].pc = 32'd0; m[k].inflight = 32'd0; m[k].target = 32'd0; m[k].parked = 32'd0;
      m[k].instr = 32'd0; m[k].ifpc = 32'd0; m[k].pc_known = 1'b0;
      m[k].parked_valid = 1'b0; m[k].draining = 1'b0;
    end
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; imem_ack = 1'b0;
    @(negedge clk);

    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pin.rst_addr", addr0, 32'h0000_0000);
    chk("pin.rst_instr", ins0, 32'h0000_0013);
    chk("pin.rst_req", {31'd0, req0}, 32'd1);
    chk("pin.rst_addr_wrap", addr1, 32'hFFFF_FFFC);

    // Zero-wait fetch of 0 and 4
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("pin.first_instr", ins0, 32'hA5A5_0000);
    chk("pin.first_addr", addr0, 32'h0000_0004);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Stall arrives with the ack for 8, held three cycles
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("pin.hold_req", {31'd0, req0}, 32'd0);
    chk("pin.hold_instr", ins0, 32'hA5A5_0004);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pin.release_pc", pc0, 32'h0000_0008);
    chk("pin.release_instr", ins0, 32'hA5A5_0008);
    chk("pin.release_addr", addr0, 32'h0000_000C);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Two-cycle wait states on 0x10 and 0x14
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pin.bubble_instr", ins0, 32'h0000_0013);
    chk("pin.bubble_pc", pc0, 32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pin.wait_addr", addr0, 32'h0000_0014);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect to 0x100 while 0x18 is outstanding without ack
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    chk("pin.kill_addr", addr0, 32'h0000_0018);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("pin.after_kill_addr", addr0, 32'h0000_0100);
    chk("pin.after_kill_instr", ins0, 32'h0000_0013);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("pin.target_pc", pc0, 32'h0000_0100);

    // Redirect to unaligned 0x203 with stall and ack together
    step(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b1);
    chk("pin.redir_addr", addr0, 32'h0000_0200);
    chk("pin.redir_instr", ins0, 32'h0000_0013);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect out of HOLD
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    chk("pin.hold_redir_addr", addr0, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Second redirect during KILL overrides the first, stall ignored
    step(1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("pin.rekill_addr", addr0, 32'h0000_0500);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset in the middle of KILL, then the wrapping instance crosses zero
    step(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pin.midkill_rst_addr", addr1, 32'hFFFF_FFFC);
    chk("pin.midkill_rst_req", {31'd0, req1}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("pin.wrap_addr", addr1, 32'h0000_0000);
    chk("pin.wrap_pc", pc1, 32'hFFFF_FFFC);
    chk("pin.wrap_instr", ins1, 32'h5A5A_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
